// File: rtl/alu_pipe_if.sv
// Request/result bundle for alu_pipe: operand handshake in, result handshake out.
// slave is the ALU side; master is the producer/consumer side.
interface alu_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       oper;
    logic             cin;
    logic             inv_a;
    logic             inv_b;
    logic             sign;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zf;
    logic             sf;
    logic             of;
    logic             cf;
    logic             busy;

    modport slave (
        input  in_valid, oper, cin, inv_a, inv_b, sign, in_a, in_b, out_ready,
        output in_ready, out_valid, out, zf, sf, of, cf, busy
    );

    modport master (
        output in_valid, oper, cin, inv_a, inv_b, sign, in_a, in_b, out_ready,
        input  in_ready, out_valid, out, zf, sf, of, cf, busy
    );
endinterface

// File: rtl/alu_pipe.sv
// Single-issue ALU with registered result/flags and valid/ready handshakes.
// Define ALU_PIPE_MUL_EN to compile in the iterative shift-add multiplier (oper 10).
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_pipe_if.slave bus
);
    // state  | meaning
    // S_IDLE | waiting for a request
    // S_MUL  | multiplier iterating, one shift-add step per cycle
    // S_HOLD | result presented until the consumer takes it
`ifdef ALU_PIPE_MUL_EN
    localparam int         CW     = $clog2(WIDTH);
    localparam logic [3:0] OP_MUL = 4'd10;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_HOLD = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd2} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zf_q, zf_d, sf_q, sf_d, of_q, of_d, cf_q, cf_d;
`ifdef ALU_PIPE_MUL_EN
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]     add_hi;
    logic [2*WIDTH-1:0] step;
`endif

    logic             in_ready, accept;
    logic [WIDTH-1:0] a_p, b_p, alu_res;
    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   sum;
    logic             alu_of, alu_cf, alu_rsv;

    // Gated by rst_n so the block never advertises readiness while held in reset.
    assign in_ready      = rst_n && ((state_q == S_IDLE) || (state_q == S_HOLD && bus.out_ready));
    assign accept        = bus.in_valid && in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == S_HOLD);
    assign bus.out       = out_q;
    assign bus.zf        = zf_q;
    assign bus.sf        = sf_q;
    assign bus.of        = of_q;
    assign bus.cf        = cf_q;
`ifdef ALU_PIPE_MUL_EN
    assign bus.busy      = (state_q == S_MUL);
`else
    assign bus.busy      = 1'b0;
`endif

    always_comb begin
        a_p     = bus.inv_a ? ~bus.in_a : bus.in_a;
        b_p     = bus.inv_b ? ~bus.in_b : bus.in_b;
        sh      = b_p[SHW-1:0];
        sum     = {1'b0, a_p} + {1'b0, b_p} + {{WIDTH{1'b0}}, bus.cin};
        alu_res = '0;
        alu_of  = 1'b0;
        alu_cf  = 1'b0;
        alu_rsv = 1'b0;
        case (bus.oper)
            4'd0: alu_res = (a_p << sh) | (a_p >> (WIDTH - int'(sh)));
            4'd1: alu_res = a_p << sh;
            4'd2: alu_res = $unsigned($signed(a_p) >>> sh);
            4'd3: alu_res = a_p >> sh;
            4'd4: begin
                alu_res = sum[WIDTH-1:0];
                alu_cf  = sum[WIDTH];
                alu_of  = bus.sign ? ((a_p[WIDTH-1] == b_p[WIDTH-1]) && (sum[WIDTH-1] != a_p[WIDTH-1]))
                                   : sum[WIDTH];
            end
            4'd5: alu_res = a_p & b_p;
            4'd6: alu_res = a_p | b_p;
            4'd7: alu_res = a_p ^ b_p;
            4'd8: for (int i = 0; i < WIDTH; i++) alu_res[i] = a_p[WIDTH-1-i];
            4'd9: alu_res = b_p;
            default: alu_rsv = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        zf_d    = zf_q;
        sf_d    = sf_q;
        of_d    = of_q;
        cf_d    = cf_q;
`ifdef ALU_PIPE_MUL_EN
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        // Upper half accumulates, whole accumulator shifts right; multiplier drains out the bottom.
        add_hi  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        step    = {add_hi, acc_q[WIDTH-1:1]};
`endif
        if (accept) begin
`ifdef ALU_PIPE_MUL_EN
            if (bus.oper == OP_MUL) begin
                state_d = S_MUL;
                mcand_d = a_p;
                acc_d   = {{WIDTH{1'b0}}, b_p};
                cnt_d   = CW'(WIDTH - 1);
            end else
`endif
            begin
                state_d = S_HOLD;
                out_d   = alu_res;
                zf_d    = ~alu_rsv & (alu_res == '0);
                sf_d    = ~alu_rsv & alu_res[WIDTH-1];
                of_d    = alu_of;
                cf_d    = alu_cf;
            end
        end else if (state_q == S_HOLD && bus.out_ready) begin
            state_d = S_IDLE;
`ifdef ALU_PIPE_MUL_EN
        end else if (state_q == S_MUL) begin
            acc_d = step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
                state_d = S_HOLD;
                out_d   = step[WIDTH-1:0];
                zf_d    = (step[WIDTH-1:0] == '0);
                sf_d    = step[WIDTH-1];
                of_d    = |step[2*WIDTH-1:WIDTH];
                cf_d    = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            zf_q    <= 1'b0;
            sf_q    <= 1'b0;
            of_q    <= 1'b0;
            cf_q    <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            zf_q    <= zf_d;
            sf_q    <= sf_d;
            of_q    <= of_d;
            cf_q    <= cf_d;
`ifdef ALU_PIPE_MUL_EN
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=16): directed vectors plus random ops
// compared against an arithmetic reference model.
module tb_alu_pipe;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic        zf;
        logic        sf;
        logic        of;
        logic        cf;
        logic        mul;
    } exp_t;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic ia, input logic ib, input logic sg);
        exp_t        e;
        logic [15:0] ap, bp, rev;
        longint      ua, ub, sa, sb, full, ss, r, pw;
        bit          rsv;
        ap  = ia ? ~a : a;
        bp  = ib ? ~b : b;
        ua  = longint'(ap);
        ub  = longint'(bp);
        sa  = (ua >= 32768) ? ua - 65536 : ua;
        sb  = (ub >= 32768) ? ub - 65536 : ub;
        pw  = longint'(2 ** int'(ub % 16));
        e   = '0;
        rsv = 1'b0;
        r   = 0;
        case (op)
            4'd0: r = (ua * pw + ua / (65536 / pw)) % 65536;
            4'd1: r = (ua * pw) % 65536;
            4'd2: begin
                r = (sa >= 0) ? sa / pw : -((-sa + pw - 1) / pw);
                if (r < 0) r = r + 65536;
            end
            4'd3: r = ua / pw;
            4'd4: begin
                full = ua + ub + longint'(cin);
                r    = full % 65536;
                e.cf = (full >= 65536);
                ss   = sa + sb + longint'(cin);
                e.of = sg ? (ss > 32767 || ss < -32768) : e.cf;
            end
            4'd5: r = longint'(ap & bp);
            4'd6: r = longint'(ap | bp);
            4'd7: r = longint'(ap ^ bp);
            4'd8: begin
                for (int i = 0; i < 16; i++) rev[i] = ap[15-i];
                r = longint'(rev);
            end
            4'd9: r = ub;
`ifdef ALU_PIPE_MUL_EN
            4'd10: begin
                full  = ua * ub;
                r     = full % 65536;
                e.of  = (full >= 65536);
                e.mul = 1'b1;
            end
`endif
            default: rsv = 1'b1;
        endcase
        e.res = r[15:0];
        e.zf  = !rsv && (r == 0);
        e.sf  = !rsv && (r >= 32768);
        return e;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic ia, input logic ib, input logic sg);
        bus.in_valid = 1'b1;
        bus.oper     = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.cin      = cin;
        bus.inv_a    = ia;
        bus.inv_b    = ib;
        bus.sign     = sg;
    endtask

    // Issue one request with out_ready=1; returns at the negedge where the result is presented.
    task automatic send(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic ia, input logic ib, input logic sg);
        exp_t e;
        int   lat, nbusy, nrdy;
        e = model(op, a, b, cin, ia, ib, sg);
        bus.out_ready = 1'b1;
        drive(op, a, b, cin, ia, ib, sg);
        #1;
        chk({tag, "_rdy"}, bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat   = 1;
        nbusy = 0;
        nrdy  = 0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.busy) nbusy++;
            if (bus.in_ready) nrdy++;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, e.mul ? 17 : 1);
        chk({tag, "_busy"}, nbusy, e.mul ? 16 : 0);
        chk({tag, "_rdy_mul"}, nrdy, 0);
        chk({tag, "_res"}, {bus.out, bus.zf, bus.sf, bus.of, bus.cf}, {e.res, e.zf, e.sf, e.of, e.cf});
    endtask

    initial begin
        int n;
        logic [3:0] rop;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.oper      = 4'd0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.cin       = 1'b0;
        bus.inv_a     = 1'b0;
        bus.inv_b     = 1'b0;
        bus.sign      = 1'b0;

        #12;
        chk("rst_state", {bus.out_valid, bus.in_ready, bus.busy, bus.zf, bus.sf, bus.of, bus.cf}, 7'b0);
        chk("rst_out", bus.out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", bus.in_ready, 1);

        send("add_ovf", 4'd4, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("add_ovf_lit", {bus.out, bus.zf, bus.sf, bus.of, bus.cf}, {16'h8000, 4'b0110});
        send("rol", 4'd0, 16'h8001, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rol_lit", bus.out, 16'h0018);
        send("sra", 4'd2, 16'h8000, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sra_lit", {bus.out, bus.sf}, {16'hFFFF, 1'b1});
        send("add_cy", 4'd4, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("add_cy_lit", {bus.out, bus.zf, bus.sf, bus.of, bus.cf}, {16'h0000, 4'b1011});
        send("rsv", 4'd13, 16'h1234, 16'h5678, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rsv_lit", {bus.out, bus.zf, bus.sf, bus.of, bus.cf}, {16'h0000, 4'b0000});
        @(negedge clk);

        // Consumer stalls: result must hold and a new request must wait.
        bus.out_ready = 1'b0;
        drive(4'd7, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(4'd9, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_hold", {bus.out_valid, bus.in_ready, bus.out}, {1'b1, 1'b0, 16'hFF00});
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("stall_release_rdy", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("stall_next", {bus.out_valid, bus.out}, {1'b1, 16'h1234});
        @(negedge clk);

        for (int i = 0; i < 4; i++)
            send("b2b_and", 4'd5, 16'(16'hFFFF >> i), 16'(16'h0FF0 << i), 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

`ifdef ALU_PIPE_MUL_EN
        send("mul", 4'd10, 16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mul_lit", {bus.out, bus.zf, bus.sf, bus.of, bus.cf}, {16'h0000, 4'b1010});
        @(negedge clk);
        drive(4'd10, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mulrst", {bus.out_valid, bus.busy, bus.in_ready, bus.out}, {3'b000, 16'h0000});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mulrst_rdy", bus.in_ready, 1);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) n++;
        end
        chk("mulrst_stale", n, 0);
`else
        send("mul_rsv", 4'd10, 16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mul_rsv_lit", {bus.out, bus.zf, bus.sf, bus.of, bus.cf, bus.busy}, {16'h0000, 5'b00000});
        @(negedge clk);
`endif

        // Reset while a result is held.
        bus.out_ready = 1'b0;
        drive(4'd6, 16'h1200, 16'h0034, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("hold_pre_rst", {bus.out_valid, bus.out}, {1'b1, 16'h1234});
        #2 rst_n = 1'b0;
        #1;
        chk("hold_rst", {bus.out_valid, bus.in_ready, bus.out}, {2'b00, 16'h0000});
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_valid) n++;
        end
        chk("hold_rst_stale", n, 0);

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            send($sformatf("rnd%0d_op%0d", i, rop), rop, 16'($urandom), 16'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
